// File: rtl/hcsr04_measurement_scheduler.sv
`default_nettype none
// ============================================================================
// hcsr04_measurement_scheduler : HC-SR04 trigger/echo sequencer, cm output
// Rev 1.0 - initial release
// ============================================================================
module hcsr04_measurement_scheduler #(
  parameter int TRIG_CYCLES    = 500,
  parameter int CM_DIV         = 2900,
  parameter int TIMEOUT_CYCLES = 1900000,
  parameter int PERIOD_CYCLES  = 3000000,
  parameter int DIST_W         = 9
) (
  input  logic              Clk_i,
  input  logic              Reset_i,
  input  logic              Enable_i,
  input  logic              Echo_i,
  output logic              Trigger_o,
  output logic [DIST_W-1:0] Distance_o,
  output logic              Distance_Available_o,
  output logic              Timeout_o,
  output logic              Busy_o
);

  localparam int PW = (PERIOD_CYCLES  > 1) ? $clog2(PERIOD_CYCLES)  : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SW = (CM_DIV         > 1) ? $clog2(CM_DIV)         : 1;

  localparam logic [PW-1:0]     c_period_last  = PW'(PERIOD_CYCLES - 1);
  localparam logic [PW-1:0]     c_trig_last    = PW'(TRIG_CYCLES - 1);
  localparam logic [TW-1:0]     c_timeout_last = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0]     c_sub_last     = SW'(CM_DIV - 1);
  localparam logic [DIST_W-1:0] c_dist_max     = '1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_HOLDOFF   = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_echo_meta;
  logic              r_echo_sync;
  logic              r_echo_prev;
  logic [PW-1:0]     r_period_cnt;
  logic [TW-1:0]     r_wait_cnt;
  logic [SW-1:0]     r_sub_cnt;
  logic [DIST_W-1:0] r_cm_cnt;

  logic              w_echo_rise;
  logic              w_echo_fall;
  logic              w_sub_wrap;
  logic [DIST_W-1:0] w_cm_next;

  // Both edges come from the same synchronised pair, so rise and fall see equal latency.
  assign w_echo_rise = r_echo_sync & ~r_echo_prev;
  assign w_echo_fall = ~r_echo_sync & r_echo_prev;
  assign w_sub_wrap  = (r_sub_cnt == c_sub_last);
  // Includes the wrap on the current clock so the result is floor(width / CM_DIV).
  assign w_cm_next   = (w_sub_wrap && (r_cm_cnt != c_dist_max)) ? r_cm_cnt + 1'b1 : r_cm_cnt;

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      r_state              <= S_IDLE;
      r_echo_meta          <= 1'b0;
      r_echo_sync          <= 1'b0;
      r_echo_prev          <= 1'b0;
      r_period_cnt         <= '0;
      r_wait_cnt           <= '0;
      r_sub_cnt            <= '0;
      r_cm_cnt             <= '0;
      Trigger_o            <= 1'b0;
      Distance_o           <= '0;
      Distance_Available_o <= 1'b0;
      Timeout_o            <= 1'b0;
      Busy_o               <= 1'b0;
    end else begin
      r_echo_meta          <= Echo_i;
      r_echo_sync          <= r_echo_meta;
      r_echo_prev          <= r_echo_sync;
      Distance_Available_o <= 1'b0;
      Timeout_o            <= 1'b0;

      if (r_period_cnt != c_period_last) begin
        r_period_cnt <= r_period_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (Enable_i) begin
            r_state      <= S_TRIG;
            r_period_cnt <= '0;
            Trigger_o    <= 1'b1;
            Busy_o       <= 1'b1;
          end
        end

        S_TRIG: begin
          // The period counter doubles as the trigger-width timer.
          if (r_period_cnt == c_trig_last) begin
            Trigger_o  <= 1'b0;
            r_wait_cnt <= '0;
            r_state    <= S_WAIT_RISE;
          end
        end

        S_WAIT_RISE: begin
          if (w_echo_rise) begin
            r_sub_cnt  <= '0;
            r_cm_cnt   <= '0;
            r_wait_cnt <= '0;
            r_state    <= S_MEASURE;
          end else if (r_wait_cnt == c_timeout_last) begin
            Timeout_o <= 1'b1;
            r_state   <= S_HOLDOFF;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        S_MEASURE: begin
          if (r_wait_cnt == c_timeout_last) begin
            Timeout_o <= 1'b1;
            r_state   <= S_HOLDOFF;
          end else if (w_echo_fall) begin
            Distance_o           <= w_cm_next;
            Distance_Available_o <= 1'b1;
            r_state              <= S_HOLDOFF;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
            r_sub_cnt  <= w_sub_wrap ? '0 : r_sub_cnt + 1'b1;
            r_cm_cnt   <= w_cm_next;
          end
        end

        S_HOLDOFF: begin
          if (r_period_cnt == c_period_last) begin
            if (Enable_i) begin
              r_state      <= S_TRIG;
              r_period_cnt <= '0;
              Trigger_o    <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              Busy_o  <= 1'b0;
            end
          end
        end

        default: begin
          r_state   <= S_IDLE;
          Trigger_o <= 1'b0;
          Busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hcsr04_measurement_scheduler.sv
`default_nettype none
// ============================================================================
// tb_hcsr04_measurement_scheduler : randomized ranging cycles vs timing model
// Rev 1.0 - initial release
// ============================================================================
module tb_hcsr04_measurement_scheduler;

  localparam int TRIG = 4;
  localparam int CMD  = 10;
  localparam int TOC  = 200;
  localparam int PER  = 400;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       echo;
  logic       Trigger_o;
  logic [8:0] Distance_o;
  logic       Distance_Available_o;
  logic       Timeout_o;
  logic       Busy_o;
  logic       trig3;
  logic [2:0] dist3;
  logic       av3;
  logic       to3;
  logic       busy3;

  int n_checks = 0;
  int n_pass   = 0;
  int ncyc     = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int last_rise = 0;
  int last_fall = 0;
  int av_n = 0;
  int av_idx = 0;
  int av_dist = 0;
  int av_dist3 = 0;
  int to_n = 0;
  int to_idx = 0;
  int mirror_err = 0;
  logic trig_prev = 1'b0;

  int prev_rise = -1;
  int exp_dist  = 0;
  int en_idx;
  int rel;
  int r0;
  int t;
  int kind;

  always #5 clk = ~clk;

  hcsr04_measurement_scheduler #(
    .TRIG_CYCLES(TRIG), .CM_DIV(CMD), .TIMEOUT_CYCLES(TOC), .PERIOD_CYCLES(PER), .DIST_W(9)
  ) dut (
    .Clk_i(clk), .Reset_i(rst), .Enable_i(en), .Echo_i(echo),
    .Trigger_o(Trigger_o), .Distance_o(Distance_o),
    .Distance_Available_o(Distance_Available_o), .Timeout_o(Timeout_o), .Busy_o(Busy_o)
  );

  hcsr04_measurement_scheduler #(
    .TRIG_CYCLES(TRIG), .CM_DIV(CMD), .TIMEOUT_CYCLES(TOC), .PERIOD_CYCLES(PER), .DIST_W(3)
  ) dut3 (
    .Clk_i(clk), .Reset_i(rst), .Enable_i(en), .Echo_i(echo),
    .Trigger_o(trig3), .Distance_o(dist3),
    .Distance_Available_o(av3), .Timeout_o(to3), .Busy_o(busy3)
  );

  // Event recorder: each negedge index names the posedge just before it.
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (Trigger_o && !trig_prev) begin rise_cnt = rise_cnt + 1; last_rise = ncyc; end
    if (!Trigger_o && trig_prev) begin fall_cnt = fall_cnt + 1; last_fall = ncyc; end
    trig_prev = Trigger_o;
    if (Distance_Available_o) begin
      av_n = av_n + 1; av_idx = ncyc; av_dist = int'(Distance_o); av_dist3 = int'(dist3);
    end
    if (Timeout_o) begin to_n = to_n + 1; to_idx = ncyc; end
    if (!rst && ({trig3, av3, to3, busy3} !== {Trigger_o, Distance_Available_o, Timeout_o, Busy_o}))
      mirror_err = mirror_err + 1;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One ranging cycle: echo rises d clocks after the trigger falls and stays high w clocks.
  task automatic measure(input int d, input int w, input bit echo_on, input bit drop_en);
    int f0, f, av0, to0, tw, e3;
    f0 = fall_cnt;
    tw = 0;
    while (fall_cnt == f0 && tw < 1000) begin tick(); tw++; end
    check_value("trigger_fall_seen", fall_cnt - f0, 1);
    if (fall_cnt == f0) return;
    f = last_fall;
    check_value("trigger_width", f - last_rise, TRIG);
    if (prev_rise >= 0) check_value("trigger_period", last_rise - prev_rise, PER);
    prev_rise = last_rise;
    av0 = av_n;
    to0 = to_n;
    if (echo_on) begin
      repeat (d) tick();
      echo = 1'b1;
      if (drop_en) en = 1'b0;
      repeat (w) tick();
      echo = 1'b0;
    end
    while (ncyc < f + PER - TRIG - 4) tick();
    check_value("busy_in_cycle", Busy_o, 1);
    if (echo_on && w < TOC) begin
      exp_dist = (w / CMD > 511) ? 511 : w / CMD;
      e3 = (w / CMD > 7) ? 7 : w / CMD;
      check_value("avail_count", av_n - av0, 1);
      check_value("timeout_count", to_n - to0, 0);
      check_value("distance", av_dist, exp_dist);
      check_value("distance_w3_sat", av_dist3, e3);
      check_value("avail_latency", av_idx - f, d + w + 3);
    end else begin
      check_value("avail_count", av_n - av0, 0);
      check_value("timeout_count", to_n - to0, 1);
      check_value("timeout_latency", to_idx - f, echo_on ? d + 3 + TOC : TOC);
    end
    check_value("distance_hold", Distance_o, exp_dist);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    echo = 1'b0;
    repeat (3) tick();
    check_value("reset_strobes", {Trigger_o, Distance_Available_o, Timeout_o, Busy_o}, 0);
    check_value("reset_distance", Distance_o, 0);
    rst = 1'b0;
    tick();
    check_value("idle_busy", Busy_o, 0);

    en = 1'b1;
    en_idx = ncyc;
    tick();
    check_value("enable_to_trigger", last_rise - en_idx, 1);

    measure(20, 125, 1'b1, 1'b0);
    measure(0, 0, 1'b0, 1'b0);
    measure(30, 300, 1'b1, 1'b0);
    measure(10, 95, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      kind = int'($urandom_range(0, 2));
      case (kind)
        0:       measure(int'($urandom_range(0, 150)), int'($urandom_range(1, 195)), 1'b1, 1'b0);
        1:       measure(0, 0, 1'b0, 1'b0);
        default: measure(int'($urandom_range(0, 60)), int'($urandom_range(210, 300)), 1'b1, 1'b0);
      endcase
    end

    // Enable drops while the echo is high; the cycle still reports, then idles.
    measure(15, 80, 1'b1, 1'b1);
    t = 0;
    while (Busy_o && t < 100) begin tick(); t++; end
    check_value("idle_after_disable", ncyc - prev_rise, PER);
    r0 = rise_cnt;
    repeat (500) tick();
    check_value("no_trigger_while_disabled", rise_cnt - r0, 0);
    check_value("busy_while_disabled", Busy_o, 0);

    // Reset in the middle of a trigger pulse.
    en = 1'b1;
    en_idx = ncyc;
    tick();
    check_value("enable_to_trigger_2", last_rise - en_idx, 1);
    tick();
    rst = 1'b1;
    tick();
    check_value("midtrig_reset_strobes", {Trigger_o, Distance_Available_o, Timeout_o, Busy_o}, 0);
    check_value("midtrig_reset_distance", Distance_o, 0);
    exp_dist = 0;
    rst = 1'b0;
    rel = ncyc;
    prev_rise = -1;
    tick();
    check_value("trigger_after_reset", last_rise - rel, 1);
    measure(5, 50, 1'b1, 1'b0);

    check_value("w3_control_mirror", mirror_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
